alu_op_sequencer: RTL

//  Command-level controller in front of the 32-bit combinational ALU (XOR/AND/OR/NOR/ADD/SLL/SR, status {V,C,N,Z}).

---
 rtl/alu_op_sequencer_pkg.sv | 65 ++++++
 rtl/alu_op_sequencer_decode.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, ALU select
// fields, status bit positions, FSM state encoding and carry-in sources.
package alu_op_sequencer_pkg;

    // Command opcodes
    localparam logic [3:0] OP_XOR   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SR    = 4'd7;
    localparam logic [3:0] OP_ADD64 = 4'd8;
    localparam logic [3:0] OP_SUB64 = 4'd9;

    // ALU function select (low three bits of select_in)
    localparam logic [2:0] SEL_XOR = 3'd0;
    localparam logic [2:0] SEL_AND = 3'd1;
    localparam logic [2:0] SEL_OR  = 3'd2;
    localparam logic [2:0] SEL_NOR = 3'd3;
    localparam logic [2:0] SEL_ADD = 3'd4;
    localparam logic [2:0] SEL_SLL = 3'd5;
    localparam logic [2:0] SEL_SR  = 3'd6;

    // Status vector bit positions {V,C,N,Z}
    localparam int unsigned ST_V = 3;
    localparam int unsigned ST_C = 2;
    localparam int unsigned ST_N = 1;
    localparam int unsigned ST_Z = 0;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    // Where the ALU carry-in comes from for the current pass
    typedef enum logic [1:0] {
        CIN_ZERO  = 2'd0,
        CIN_ONE   = 2'd1,
        CIN_CARRY = 2'd2
    } cin_src_e;

    // Pack {invA, invB, op} into the ALU select_in field
    function automatic logic [4:0] mk_sel(input logic inv_a, input logic inv_b,
                                          input logic [2:0] fn);
        return {inv_a, inv_b, fn};
    endfunction

    // Opcode legality; wide opcodes exist only when enabled
    function automatic logic op_legal(input logic [3:0] op, input logic en_wide);
        logic ok;
        ok = 1'b0;
        if (op <= OP_SR) begin
            ok = 1'b1;
        end else if ((op == OP_ADD64) || (op == OP_SUB64)) begin
            ok = en_wide;
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode decoder: maps a command opcode and pass (lo/hi)
// to the ALU select field, the carry-in source and the legal/wide flags.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned EN_WIDE = 1
) (
    input  logic [3:0] op_i,
    input  logic       hi_pass_i,
    output logic [4:0] sel_o,
    output logic [1:0] cin_src_o,
    output logic       legal_o,
    output logic       wide_o
);

    localparam logic WIDE_OK = (EN_WIDE != 0);

    // Decode opcode into ALU controls for the selected pass
    always_comb begin
        sel_o     = '0;
        cin_src_o = CIN_ZERO;
        legal_o   = op_legal(op_i, WIDE_OK);
        wide_o    = 1'b0;
        case (op_i)
            OP_XOR: sel_o = mk_sel(1'b0, 1'b0, SEL_XOR);
            OP_AND: sel_o = mk_sel(1'b0, 1'b0, SEL_AND);
            OP_OR:  sel_o = mk_sel(1'b0, 1'b0, SEL_OR);
            OP_NOR: sel_o = mk_sel(1'b0, 1'b0, SEL_NOR);
            OP_ADD: sel_o = mk_sel(1'b0, 1'b0, SEL_ADD);
            OP_SUB: begin
                sel_o     = mk_sel(1'b0, 1'b1, SEL_ADD);
                cin_src_o = CIN_ONE;
            end
            OP_SLL: sel_o = mk_sel(1'b0, 1'b0, SEL_SLL);
            OP_SR:  sel_o = mk_sel(1'b0, 1'b0, SEL_SR);
            OP_ADD64: begin
                if (WIDE_OK) begin
                    wide_o    = 1'b1;
                    sel_o     = mk_sel(1'b0, 1'b0, SEL_ADD);
                    cin_src_o = hi_pass_i ? CIN_CARRY : CIN_ZERO;
                end
            end
            OP_SUB64: begin
                if (WIDE_OK) begin
                    wide_o    = 1'b1;
                    sel_o     = mk_sel(1'b0, 1'b1, SEL_ADD);
                    cin_src_o = hi_pass_i ? CIN_CARRY : CIN_ONE;
                end
            end
            default: begin
                sel_o     = '0;
                cin_src_o = CIN_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-level controller in front of a combinational 32-bit ALU.
// Captures one command, runs one or two ALU passes (64-bit add/sub chain
// the carry of the low pass), registers result and status and returns
// them over a valid/ready response channel.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned EN_WIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [2*DATA_W-1:0]   cmd_a,
    input  logic [2*DATA_W-1:0]   cmd_b,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [4:0]            alu_sel,
    output logic                  alu_cin,
    input  logic [DATA_W-1:0]     alu_f,
    input  logic [3:0]            alu_status,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_f,
    output logic [3:0]            rsp_status,
    output logic                  rsp_err
);

    localparam logic WIDE_OK = (EN_WIDE != 0);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [2*DATA_W-1:0]   a_q, a_d;
    logic [2*DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]     f_lo_q, f_lo_d;
    logic [DATA_W-1:0]     f_hi_q, f_hi_d;
    logic [3:0]            status_q, status_d;
    logic                  err_q, err_d;
    logic                  c_lo_q, c_lo_d;

    logic                  cmd_legal;
    logic                  accept;
    logic [4:0]            dec_sel;
    logic [1:0]            dec_cin;
    logic                  dec_legal;
    logic                  dec_wide;

    // The decoder only ever sees the captured opcode, so the ALU drive has
    // no combinational path from the command port.
    alu_op_decode #(
        .EN_WIDE (EN_WIDE)
    ) u_decode (
        .op_i      (op_q),
        .hi_pass_i (state_q == S_EXEC_HI),
        .sel_o     (dec_sel),
        .cin_src_o (dec_cin),
        .legal_o   (dec_legal),
        .wide_o    (dec_wide)
    );

    assign cmd_legal = op_legal(cmd_op, WIDE_OK);
    assign accept    = (state_q == S_IDLE) && cmd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_legal ? S_EXEC_LO : S_RESP;
                end
            end
            S_EXEC_LO: state_d = (dec_legal && dec_wide) ? S_EXEC_HI : S_RESP;
            S_EXEC_HI: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and ALU drive outputs, decoded from registered state only
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        alu_cin   = 1'b0;
        if (((state_q == S_EXEC_LO) || (state_q == S_EXEC_HI)) && dec_legal) begin
            if (state_q == S_EXEC_HI) begin
                alu_a = a_q[2*DATA_W-1:DATA_W];
                alu_b = b_q[2*DATA_W-1:DATA_W];
            end else begin
                alu_a = a_q[DATA_W-1:0];
                alu_b = b_q[DATA_W-1:0];
            end
            alu_sel = dec_sel;
            case (dec_cin)
                CIN_ONE:   alu_cin = 1'b1;
                CIN_CARRY: alu_cin = c_lo_q;
                default:   alu_cin = 1'b0;
            endcase
        end
    end

    // Datapath next-state: capture command, collect pass results
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        f_lo_d   = f_lo_q;
        f_hi_d   = f_hi_q;
        status_d = status_q;
        err_d    = err_q;
        c_lo_d   = c_lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = cmd_op;
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    f_lo_d   = '0;
                    f_hi_d   = '0;
                    status_d = '0;
                    err_d    = ~cmd_legal;
                    c_lo_d   = 1'b0;
                end
            end
            S_EXEC_LO: begin
                f_lo_d   = alu_f;
                status_d = alu_status;
                c_lo_d   = alu_status[ST_C];
            end
            S_EXEC_HI: begin
                // V,C,N come from the high pass; Z must hold across both halves.
                f_hi_d         = alu_f;
                status_d       = alu_status;
                status_d[ST_Z] = status_q[ST_Z] & alu_status[ST_Z];
            end
            default: begin
                op_d = op_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f_lo_q   <= '0;
            f_hi_q   <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
            c_lo_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f_lo_q   <= f_lo_d;
            f_hi_q   <= f_hi_d;
            status_q <= status_d;
            err_q    <= err_d;
            c_lo_q   <= c_lo_d;
        end
    end

    assign rsp_f      = {f_hi_q, f_lo_q};
    assign rsp_status = status_q;
    assign rsp_err    = err_q;

endmodule
